// File: rtl/sseg_scan_controller.sv
// Time-multiplexed N-digit common-anode seven-segment scan controller with
// refresh prescaler, anode dead-time, PWM brightness and per-digit blank/dp.
module sseg_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 1,
   parameter int BRIGHT_W    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NUM_DIGITS*7-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              sseg,
   output logic                    dp,
   output logic                    frame_tick
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int DIG_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [DIG_W-1:0]      digit_q, digit_d;
   logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            sseg_q, sseg_d;
   logic                  dp_q, dp_d;
   logic                  frame_q, frame_d;

   logic       guard_ok;
   logic       slot_end;
   logic       lit;
   logic [6:0] seg_arr [NUM_DIGITS];

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_seg_unpack
      assign seg_arr[k] = seg_in[7*k +: 7];
   end

   // A zero guard would make the comparison trivially true, so it is elided.
   if (GUARD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
   end else begin : g_guard
      assign guard_ok = (pre_q >= PRE_W'(GUARD));
   end

   assign slot_end = (pre_q == PRE_LAST);

   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin
      pre_d   = '0;
      digit_d = '0;
      pwm_d   = '0;
      if (enable) begin
         pre_d   = slot_end ? '0 : pre_q + PRE_W'(1);
         digit_d = digit_q;
         if (slot_end) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
         end
         pwm_d = pwm_q + BRIGHT_W'(1);
      end
   end

   always_comb begin
      lit = enable && guard_ok && !blank_in[digit_q] &&
            ((&brightness) || (pwm_q < brightness));

      an_d   = '1;
      sseg_d = 7'h7F;
      dp_d   = 1'b1;
      if (lit) begin
         an_d[digit_q] = 1'b0;
         sseg_d        = seg_arr[digit_q];
         dp_d          = ~dp_in[digit_q];
      end

      frame_d = enable && (digit_q == DIG_LAST) && slot_end;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q   <= '0;
         digit_q <= '0;
         pwm_q   <= '0;
         an_q    <= '1;
         sseg_q  <= 7'h7F;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         digit_q <= digit_d;
         pwm_q   <= pwm_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
         dp_q    <= dp_d;
         frame_q <= frame_d;
      end
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign dp         = dp_q;
   assign frame_tick = frame_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Self-checking bench: two controller instances (4-digit and 8-digit) driven with
// directed and random stimulus, compared every cycle against an arithmetic scan model.
module tb_sseg_scan_controller;

   localparam int NA = 4, RDA = 4, GA = 1, BWA = 2, SWA = NA * 7;
   localparam int NB = 8, RDB = 3, GB = 2, BWB = 3, SWB = NB * 7;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] sseg;
      logic       dp;
      logic       ft;
   } exp_t;

   localparam exp_t EXP_RST = '{an: 8'hFF, sseg: 7'h7F, dp: 1'b1, ft: 1'b0};

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;

   logic [SWA-1:0] seg_a;
   logic [NA-1:0]  dp_a, blank_a, an_a;
   logic [BWA-1:0] bright_a;
   logic [6:0]     sseg_a;
   logic           dpo_a, ft_a;

   logic [SWB-1:0] seg_b;
   logic [NB-1:0]  dp_b, blank_b, an_b;
   logic [BWB-1:0] bright_b;
   logic [6:0]     sseg_b;
   logic           dpo_b, ft_b;

   int   checks = 0;
   int   errors = 0;
   int   t_a = 0;
   int   t_b = 0;
   exp_t exp_a = EXP_RST;
   exp_t exp_b = EXP_RST;
   bit   rnd_mode = 0;
   bit   rnd_en = 0;

   always #5 clk = ~clk;

   sseg_scan_controller #(.NUM_DIGITS(NA), .REFRESH_DIV(RDA), .GUARD(GA), .BRIGHT_W(BWA)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_a), .dp_in(dp_a),
      .blank_in(blank_a), .brightness(bright_a), .an(an_a), .sseg(sseg_a), .dp(dpo_a),
      .frame_tick(ft_a));

   sseg_scan_controller #(.NUM_DIGITS(NB), .REFRESH_DIV(RDB), .GUARD(GB), .BRIGHT_W(BWB)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_b), .dp_in(dp_b),
      .blank_in(blank_b), .brightness(bright_b), .an(an_b), .sseg(sseg_b), .dp(dpo_b),
      .frame_tick(ft_b));

   // t = enabled cycles since the scan (re)started; everything derives from it.
   function automatic exp_t model(int n, int rd, int g, int bw, int t, logic en,
                                  logic [7:0] blank, logic [7:0] dpi, logic [55:0] seg,
                                  int bright);
      exp_t m;
      int   slot = t % rd;
      int   dig  = (t / rd) % n;
      int   pwm  = t % (1 << bw);
      bit   lit;
      lit    = en && slot >= g && !blank[dig] && (bright == (1 << bw) - 1 || pwm < bright);
      m      = EXP_RST;
      if (lit) begin
         m.an[dig] = 1'b0;
         m.sseg    = seg[dig*7 +: 7];
         m.dp      = ~dpi[dig];
      end
      m.ft = en && ((t % (n * rd)) == n * rd - 1);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("a_an",   8'(an_a),   8'(exp_a.an[NA-1:0]));
      chk("a_sseg", 8'(sseg_a), 8'(exp_a.sseg));
      chk("a_dp",   8'(dpo_a),  8'(exp_a.dp));
      chk("a_ft",   8'(ft_a),   8'(exp_a.ft));
      chk("b_an",   an_b,       exp_b.an);
      chk("b_sseg", 8'(sseg_b), 8'(exp_b.sseg));
      chk("b_dp",   8'(dpo_b),  8'(exp_b.dp));
      chk("b_ft",   8'(ft_b),   8'(exp_b.ft));
   endtask

   task automatic drive();
      if (rnd_mode) begin
         seg_a    = SWA'($urandom);
         dp_a     = NA'($urandom);
         blank_a  = NA'($urandom & $urandom & $urandom);
         bright_a = BWA'($urandom);
         seg_b    = SWB'({$urandom, $urandom});
         dp_b     = NB'($urandom);
         blank_b  = NB'($urandom & $urandom & $urandom);
         bright_b = BWB'($urandom);
         if (rnd_en) enable = ($urandom_range(0, 15) != 0);
      end
   endtask

   task automatic predict();
      if (reset) begin
         exp_a = EXP_RST;
         exp_b = EXP_RST;
         t_a   = 0;
         t_b   = 0;
      end else begin
         exp_a = model(NA, RDA, GA, BWA, t_a, enable, 8'(blank_a), 8'(dp_a), 56'(seg_a),
                       int'(bright_a));
         exp_b = model(NB, RDB, GB, BWB, t_b, enable, blank_b, dp_b, seg_b, int'(bright_b));
         t_a   = enable ? t_a + 1 : 0;
         t_b   = enable ? t_b + 1 : 0;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_all();
   endtask

   task automatic settle();
      drive();
      predict();
   endtask

   task automatic cycle();
      sample();
      settle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      seg_a    = {7'h40, 7'h79, 7'h24, 7'h30};
      dp_a     = '0;
      blank_a  = '0;
      bright_a = '1;
      seg_b    = SWB'({$urandom, $urandom});
      dp_b     = '0;
      blank_b  = '0;
      bright_b = '1;

      // Reset held: outputs idle.
      repeat (3) cycle();

      // Basic scan from release.
      sample();
      reset  = 1'b0;
      enable = 1'b1;
      settle();
      repeat (40) cycle();

      // Blank and decimal point.
      sample();
      blank_a = 4'b0100;
      dp_a    = 4'b0001;
      blank_b = 8'b0010_0000;
      dp_b    = 8'b1000_0001;
      settle();
      repeat (32) cycle();

      // Enable dropped mid digit-2 slot for 5 cycles.
      sample();
      blank_a = '0;
      settle();
      found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         cycle();
         found = (((t_a / RDA) % NA) == 2) && ((t_a % RDA) == 2);
      end
      chk("reach_digit2", 8'(found), 8'd1);
      sample();
      enable = 1'b0;
      settle();
      repeat (4) cycle();
      sample();
      enable = 1'b1;
      settle();
      repeat (24) cycle();

      // PWM dimming, then dark.
      sample();
      bright_a = 2'd2;
      bright_b = 3'd1;
      settle();
      repeat (64) cycle();
      sample();
      bright_a = '0;
      bright_b = '0;
      settle();
      repeat (64) cycle();

      // Asynchronous reset between edges while digit 1 is lit.
      sample();
      bright_a = '1;
      bright_b = '1;
      settle();
      found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         cycle();
         found = (exp_a.an[NA-1:0] == 4'b1101);
      end
      chk("reach_digit1", 8'(found), 8'd1);
      @(posedge clk);
      #2;
      chk("pre_rst_an", 8'(an_a), 8'b0000_1101);
      reset = 1'b1;
      #1;
      chk("async_an_a",   8'(an_a),   8'h0F);
      chk("async_sseg_a", 8'(sseg_a), 8'h7F);
      chk("async_an_b",   an_b,       8'hFF);
      exp_a = EXP_RST;
      exp_b = EXP_RST;
      t_a   = 0;
      t_b   = 0;
      sample();
      reset = 1'b0;
      settle();
      repeat (40) cycle();

      // Randomised inputs with occasional enable drops.
      rnd_mode = 1;
      rnd_en   = 1;
      repeat (600) cycle();

      sample();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
